store_merge: RTL and testbench

Store-side counterpart of the load-byte extraction path in the data-memory stage. It performs `sb` (store byte) as a read-modify-write on the word-wide data memory, and `sw` (store word) as a direct write. It sits between the datapath's store request and the single-port data memory. It owns the memory port while busy, and it places the byte in the same lane the load path extracts from: offset 0 maps to bits [7:0], little-endian.

---
 rtl/store_merge.sv | 92 +++++++++
 tb/tb_store_merge.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/store_merge.sv
// Store path to single-port data memory: sw is a direct write, sb is a read-modify-write of one byte lane.
// Latency: sb done 3 cycles after accepted req (READ, WRITE, DONE); sw done 2 cycles after (WRITE, DONE).
// Backpressure: busy is high while a store is in flight; req is ignored while busy and never queued.
module store_merge (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [9:0]  addr,
  input  logic [31:0] din,
  input  logic        sb,
  output logic        busy,
  output logic        done,
  output logic [7:0]  mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic        sb_q, sb_d;
  logic [31:0] merged;

  // State register and captured request; reset aborts any store in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      sb_q    <= sb_d;
    end
  end

  // Next state; the request is captured only when accepted in IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    sb_d    = sb_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          din_d   = din;
          sb_d    = sb;
          state_d = sb ? S_READ : S_WRITE;
        end
      end
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Byte lane merge: read word from the READ cycle with one little-endian lane replaced.
  always_comb begin
    merged = mem_rdata;
    case (addr_q[1:0])
      2'd0:    merged[7:0]   = din_q[7:0];
      2'd1:    merged[15:8]  = din_q[7:0];
      2'd2:    merged[23:16] = din_q[7:0];
      default: merged[31:24] = din_q[7:0];
    endcase
  end

  // Outputs decoded from state; write data is forced to zero outside WRITE.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    mem_we    = (state_q == S_WRITE);
    mem_addr  = addr_q[9:2];
    mem_wdata = '0;
    if (state_q == S_WRITE) begin
      mem_wdata = sb_q ? merged : din_q;
    end
  end

endmodule

// File: tb/tb_store_merge.sv
// Bench for store_merge: behavioural registered-read memory plus a write scoreboard.
// Expected writes are computed from a shadow memory when each store is issued.
// Cycle-exact busy/mem_we/done checks per store; a write monitor pops the scoreboard.
module tb_store_merge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] din = '0;
  logic        sb = 1'b0;
  logic        busy, done, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  store_merge dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .addr      (addr),
    .din       (din),
    .sb        (sb),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory with registered 1-cycle read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every mem_we cycle must match the oldest expected write.
  always @(negedge clk) begin
    chk("we_with_done", 32'(mem_we & done), 32'd0);
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(mem_we), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mon_e.a));
        chk("wr_data", mem_wdata, mon_e.d);
      end
    end
  end

  task automatic push_exp(input logic sbit, input logic [9:0] a, input logic [31:0] d);
    logic [31:0] w;
    wr_t e;
    w = sbit ? ref_mem[a[9:2]] : d;
    if (sbit) w[8*a[1:0] +: 8] = d[7:0];
    ref_mem[a[9:2]] = w;
    e.a = a[9:2];
    e.d = w;
    exp_q.push_back(e);
  endtask

  // Issue one store from an IDLE negedge; optionally keep req high with other data while busy.
  task automatic do_store(input logic sbit, input logic [9:0] a, input logic [31:0] d, input logic junk);
    int n;
    n = sbit ? 3 : 2;
    push_exp(sbit, a, d);
    req = 1'b1; sb = sbit; addr = a; din = d;
    @(posedge clk);
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (junk) begin
          addr = a ^ 10'h155;
          din  = ~d;
        end else begin
          req = 1'b0;
        end
      end
      if (c == n) req = 1'b0;
      chk("busy", 32'(busy), 32'(c <= n));
      chk("mem_we", 32'(mem_we), 32'(c == n - 1));
      chk("done", 32'(done), 32'(c == n));
      chk("mem_addr", 32'(mem_addr), 32'(a[9:2]));
      if (c != n - 1) chk("wdata_idle", mem_wdata, 32'd0);
    end
  endtask

  initial begin
    logic [9:0]  ra;
    logic [31:0] rd;
    logic        rs;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'd0;
      ref_mem[i] = 32'd0;
    end
    mem[2]     = 32'h1122_3344;
    ref_mem[2] = 32'h1122_3344;
    mem_rdata  = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Byte RMW at offset 1 of word 2
    do_store(1'b1, 10'h009, 32'hFFFF_FFAB, 1'b0);
    chk("rmw_word2", mem[2], 32'h1122_AB44);

    // All four lanes, each into a fresh zero word
    for (int k = 0; k < 4; k++) begin
      do_store(1'b1, 10'((4 + k) * 4 + k), 32'h0000_0080, 1'b0);
    end
    chk("lane0", mem[4], 32'h0000_0080);
    chk("lane1", mem[5], 32'h0000_8000);
    chk("lane2", mem[6], 32'h0080_0000);
    chk("lane3", mem[7], 32'h8000_0000);

    // Word store with unaligned low bits
    do_store(1'b0, 10'h3FF, 32'hDEAD_BEEF, 1'b0);
    chk("word_ff", mem[255], 32'hDEAD_BEEF);

    // Requests while busy are ignored
    do_store(1'b1, 10'h00E, 32'h0000_00C3, 1'b1);
    do_store(1'b0, 10'h020, 32'h1234_5678, 1'b1);
    chk("busy_ign_b", mem[3], 32'h00C3_0000);
    chk("busy_ign_w", mem[8], 32'h1234_5678);

    // Reset during READ: outputs clear at once, store dropped
    req = 1'b1; sb = 1'b1; addr = 10'h00C; din = 32'h0000_0055;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'd0);
    req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    chk("post_rst_mem3", mem[3], 32'h00C3_0000);

    // Back-to-back byte stores with req held high
    push_exp(1'b1, {8'd9, 2'd0}, 32'h0000_0011);
    push_exp(1'b1, {8'd9, 2'd1}, 32'h0000_0022);
    push_exp(1'b1, {8'd9, 2'd3}, 32'h0000_0033);
    req = 1'b1; sb = 1'b1; addr = {8'd9, 2'd0}; din = 32'h0000_0011;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin addr = {8'd9, 2'd1}; din = 32'h0000_0022; end
      if (c == 5) begin addr = {8'd9, 2'd3}; din = 32'h0000_0033; end
      if (c == 11) req = 1'b0;
      chk("b2b_done", 32'(done), 32'(c == 3 || c == 7 || c == 11));
      chk("b2b_busy", 32'(busy), 32'(!(c == 4 || c == 8 || c == 12)));
    end
    chk("b2b_word9", mem[9], 32'h3300_2211);

    // Random mix of byte and word stores
    for (int i = 0; i < 24; i++) begin
      ra = 10'($urandom_range(64, 127));
      rd = $urandom;
      rs = 1'($urandom_range(0, 1));
      do_store(rs, ra, rd, 1'($urandom_range(0, 1)));
    end
    for (int w = 16; w < 32; w++) begin
      chk("rand_mem", mem[w], ref_mem[w]);
    end

    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
